sweep_extinguisher: RTL and testbench

Parametrised sweep controller: the next generation of the single-nozzle extinguisher driver. It steps a nozzle `position` through `ACTIVE_LEN` positions, then rests for the remainder of a `PERIOD`-cycle frame. It adds optional ping-pong direction reversal, pause/resume on `enable`, and a frame-complete pulse. It sits between the fire-detect logic, which drives `enable` and `mode`, and the nozzle actuator decoder, which consumes `active` and `position`.

---
 rtl/sweep_pkg.sv | 18 +
 rtl/sweep_step_counter.sv | 26 ++
 rtl/sweep_extinguisher.sv | 103 ++++++++++
 tb/tb_sweep_extinguisher.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types and helpers for the sweep extinguisher slice.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        REST
    } sweep_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Width of a step index covering 0..period-1, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned period);
        return (period > 2) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/sweep_step_counter.sv
// sweep_step_counter: mod-PERIOD step index with enable and end-of-frame flag.
module sweep_step_counter
    import sweep_pkg::*;
#(
    parameter int unsigned PERIOD = 16,
    parameter int unsigned K_W    = idx_width(PERIOD)
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           en,
    output logic [K_W-1:0] k,
    output logic           last
);

    assign last = (k == K_W'(PERIOD - 1));

    // Advance one step per enabled edge, wrapping after PERIOD-1.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            k <= '0;
        end else if (en) begin
            k <= last ? '0 : k + 1'b1;
        end
    end

endmodule

// File: rtl/sweep_extinguisher.sv
// sweep_extinguisher: nozzle sweep controller with rest phase and frame pulse.
// Optional feature macro: SWEEP_EXT_PINGPONG_EN (mode=1 alternates frame direction).
module sweep_extinguisher
    import sweep_pkg::*;
#(
    parameter int unsigned POS_W      = 3,
    parameter int unsigned ACTIVE_LEN = 8,
    parameter int unsigned PERIOD     = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             enable,
    input  logic             mode,
    output logic             active,
    output logic [POS_W-1:0] position,
    output logic             resting,
    output logic             frame_done
);

    localparam int unsigned K_W = idx_width(PERIOD);
    // One extra bit so ACTIVE_LEN == 2**K_W still compares correctly.
    localparam logic [K_W:0] ACT_LEN_X = (K_W + 1)'(ACTIVE_LEN);

    logic [K_W-1:0]   k;
    logic             last;
    logic             in_sweep;
    logic [K_W-1:0]   k_rev;
    logic             dir;

    sweep_state_t     st_q, st_d;
    logic             active_d;
    logic [POS_W-1:0] position_d;
    logic             resting_d;
    logic             frame_done_d;

    sweep_step_counter #(
        .PERIOD (PERIOD),
        .K_W    (K_W)
    ) u_step (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (enable),
        .k     (k),
        .last  (last)
    );

    assign in_sweep = ({1'b0, k} < ACT_LEN_X);
    assign k_rev    = K_W'(ACTIVE_LEN - 1) - k;

`ifdef SWEEP_EXT_PINGPONG_EN
    // Direction for the next frame, decided from mode on the frame's final step.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            dir <= DIR_FWD;
        end else if (enable && last) begin
            dir <= (mode && (dir == DIR_FWD)) ? DIR_REV : DIR_FWD;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign dir         = DIR_FWD;
`endif

    // Next state and next registered outputs for the current step index.
    always_comb begin
        st_d         = st_q;
        active_d     = 1'b0;
        position_d   = position;
        resting_d    = resting;
        frame_done_d = 1'b0;
        if (enable) begin
            frame_done_d = last;
            if (in_sweep) begin
                st_d       = SWEEP;
                active_d   = 1'b1;
                resting_d  = 1'b0;
                position_d = (dir == DIR_FWD) ? POS_W'(k) : POS_W'(k_rev);
            end else begin
                st_d      = REST;
                resting_d = 1'b1;
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st_q       <= IDLE;
            active     <= 1'b0;
            position   <= '0;
            resting    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            st_q       <= st_d;
            active     <= active_d;
            position   <= position_d;
            resting    <= resting_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_sweep_extinguisher.sv
// tb_sweep_extinguisher: directed checks of the sweep controller (default and 4/4 build).
module tb_sweep_extinguisher;

`ifdef SWEEP_EXT_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr_n;
    logic       enable;
    logic       mode;
    logic       active,  resting,  frame_done;
    logic [2:0] position;
    logic       active4, resting4, frame_done4;
    logic [1:0] position4;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    sweep_extinguisher #(
        .POS_W      (3),
        .ACTIVE_LEN (8),
        .PERIOD     (16)
    ) u_dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .enable     (enable),
        .mode       (mode),
        .active     (active),
        .position   (position),
        .resting    (resting),
        .frame_done (frame_done)
    );

    sweep_extinguisher #(
        .POS_W      (2),
        .ACTIVE_LEN (4),
        .PERIOD     (4)
    ) u_dut4 (
        .clk        (clk),
        .clr_n      (clr_n),
        .enable     (enable),
        .mode       (1'b0),
        .active     (active4),
        .position   (position4),
        .resting    (resting4),
        .frame_done (frame_done4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        clr_n  = 1'b0;
        step();
        step();
        chk("rst_active",   {31'd0, active},     32'd0);
        chk("rst_position", {29'd0, position},   32'd0);
        chk("rst_resting",  {31'd0, resting},    32'd0);
        chk("rst_fdone",    {31'd0, frame_done}, 32'd0);
        clr_n = 1'b1;
    endtask

    // Check one output cycle of the 8/16 instance at frame index j, direction rev.
    task automatic chk_frame(input string tag, input int j, input bit rev);
        int exp_pos;
        if (j < 8) exp_pos = rev ? 7 - j : j;
        else       exp_pos = rev ? 0 : 7;
        chk({tag, "_active"},  {31'd0, active},     (j < 8)  ? 32'd1 : 32'd0);
        chk({tag, "_position"},{29'd0, position},   32'(exp_pos));
        chk({tag, "_resting"}, {31'd0, resting},    (j >= 8) ? 32'd1 : 32'd0);
        chk({tag, "_fdone"},   {31'd0, frame_done}, (j == 15) ? 32'd1 : 32'd0);
    endtask

    initial begin
        clr_n  = 1'b0;
        enable = 1'b0;
        mode   = 1'b0;

        // Continuous forward frames.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            chk_frame("fwd", i % 16, 1'b0);
        end

        // Ping-pong: reverse on odd frames only when the feature is built in.
        do_reset();
        mode   = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 48; i++) begin
            step();
            chk_frame("pp", i % 16, PP && ((i / 16) % 2 == 1));
        end

        // Mid-frame mode changes only steer the following frame.
        do_reset();
        mode   = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 48; i++) begin
            if (i == 3)  mode = 1'b0;
            if (i == 19) mode = 1'b1;
            step();
            chk_frame("modechg", i % 16, PP && (i >= 32));
        end
        mode = 1'b0;

        // Pause after position 4, then resume at 5.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("pause_pre_pos", {29'd0, position}, 32'd4);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("pause_active", {31'd0, active},   32'd0);
            chk("pause_pos",    {29'd0, position}, 32'd4);
        end
        enable = 1'b1;
        step();
        chk("resume_active", {31'd0, active},   32'd1);
        chk("resume_pos",    {29'd0, position}, 32'd5);

        // Toggling enable: one step per enabled edge, inactive after disabled edges.
        enable = 1'b0;
        step();
        chk("tog_idle_active", {31'd0, active}, 32'd0);
        enable = 1'b1;
        step();
        chk("tog_pos", {29'd0, position}, 32'd6);
        chk("tog_active", {31'd0, active}, 32'd1);

        // Asynchronous clear mid-sweep at position 6.
        #2;
        clr_n = 1'b0;
        #1;
        chk("aclr_active",   {31'd0, active},     32'd0);
        chk("aclr_position", {29'd0, position},   32'd0);
        chk("aclr_resting",  {31'd0, resting},    32'd0);
        chk("aclr_fdone",    {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        step();
        chk("aclr_restart_pos",    {29'd0, position}, 32'd0);
        chk("aclr_restart_active", {31'd0, active},   32'd1);

        // Rest-less 4/4 instance: no rest phase, pulse every 4th output.
        do_reset();
        chk("p4_rst_position", {30'd0, position4}, 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("p4_active",   {31'd0, active4},     32'd1);
            chk("p4_position", {30'd0, position4},   32'(i % 4));
            chk("p4_resting",  {31'd0, resting4},    32'd0);
            chk("p4_fdone",    {31'd0, frame_done4}, (i % 4 == 3) ? 32'd1 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
